fetch_wf_scheduler: RTL and testbench

- Round-robin scheduler that picks which wavefront slot in the fetch unit issues the next instruction fetch to the instruction memory port.
- Tracks per-slot state: active (dispatched, not done) and branch-blocked (fetched a branch, waiting for resolution).
- Issues one fetch at a time through a valid/ack request handshake and retires it on the response.
- Sits between wavefront dispatch/retire, the instruction buffer space flags and the instruction memory interface.

---
 rtl/fetch_wf_scheduler_if.sv | 27 ++
 rtl/fetch_wf_scheduler.sv | 177 +++++++++++++++++
 tb/tb_fetch_wf_scheduler.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_wf_scheduler_if.sv
// Instruction-memory fetch port between the wavefront fetch scheduler and
// instruction memory.
//   fetch_req_valid / fetch_req_wfid : request from scheduler, held until ack
//   fetch_req_ack                    : memory accepted the request
//   fetch_rsp_valid / fetch_rsp_wfid : fetch data returned for a slot
//   fetch_rsp_is_branch              : returned instruction is a branch
// master = scheduler side, slave = memory side.
interface fetch_wf_scheduler_if #(
  parameter int WF_ID_W = 6
);
  logic               fetch_req_valid;
  logic [WF_ID_W-1:0] fetch_req_wfid;
  logic               fetch_req_ack;
  logic               fetch_rsp_valid;
  logic [WF_ID_W-1:0] fetch_rsp_wfid;
  logic               fetch_rsp_is_branch;

  modport master (
    output fetch_req_valid, fetch_req_wfid,
    input  fetch_req_ack, fetch_rsp_valid, fetch_rsp_wfid, fetch_rsp_is_branch
  );

  modport slave (
    input  fetch_req_valid, fetch_req_wfid,
    output fetch_req_ack, fetch_rsp_valid, fetch_rsp_wfid, fetch_rsp_is_branch
  );
endinterface

// File: rtl/fetch_wf_scheduler.sv
// Round-robin fetch scheduler over NUM_WF wavefront slots.
// Each slot tracks active/blocked state; the scheduler grants one eligible
// slot (active & ~blocked & ibuf_space) at a time, holds the request on the
// fetch interface until ack, then waits for the matching response.
// Ports:
//   clk, rst              : clock, synchronous active-low reset
//   wf_dispatch_*         : slot becomes active (clears blocked)
//   wf_done_*             : slot retires (clears active and blocked)
//   br_resolve_*          : branch resolved, unblock slot
//   ibuf_space[NUM_WF]    : per-slot instruction buffer room
//   fetch (master)        : fetch request / response handshake
//   active_mask, busy     : per-slot active bits, FSM not IDLE

// Per-slot active/blocked state.
module fetch_wf_slot #(
  parameter int                 WF_ID_W = 6,
  parameter logic [WF_ID_W-1:0] SLOT_ID = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_disp_valid,
  input  logic [WF_ID_W-1:0] i_disp_id,
  input  logic               i_done_valid,
  input  logic [WF_ID_W-1:0] i_done_id,
  input  logic               i_res_valid,
  input  logic [WF_ID_W-1:0] i_res_id,
  input  logic               i_blk_valid,
  input  logic [WF_ID_W-1:0] i_blk_id,
  output logic               o_active,
  output logic               o_blocked
);
  logic r_active, r_blocked;
  logic w_disp, w_done, w_res, w_blk;

  // Ids outside the slot range never match any SLOT_ID, so they are dropped.
  assign w_disp = i_disp_valid && (i_disp_id == SLOT_ID);
  assign w_done = i_done_valid && (i_done_id == SLOT_ID);
  assign w_res  = i_res_valid  && (i_res_id  == SLOT_ID);
  assign w_blk  = i_blk_valid  && (i_blk_id  == SLOT_ID);

  // Priority: done > dispatch > branch block > resolve.
  // Block only lands on a still-active slot so a retired slot stays clean.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_active  <= 1'b0;
      r_blocked <= 1'b0;
    end else if (w_done) begin
      r_active  <= 1'b0;
      r_blocked <= 1'b0;
    end else if (w_disp) begin
      r_active  <= 1'b1;
      r_blocked <= 1'b0;
    end else if (w_blk && r_active) begin
      r_blocked <= 1'b1;
    end else if (w_res) begin
      r_blocked <= 1'b0;
    end
  end

  assign o_active  = r_active;
  assign o_blocked = r_blocked;
endmodule

module fetch_wf_scheduler #(
  parameter int NUM_WF  = 40,
  parameter int WF_ID_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wf_dispatch_valid,
  input  logic [WF_ID_W-1:0]  wf_dispatch_id,
  input  logic                wf_done_valid,
  input  logic [WF_ID_W-1:0]  wf_done_id,
  input  logic                br_resolve_valid,
  input  logic [WF_ID_W-1:0]  br_resolve_id,
  input  logic [NUM_WF-1:0]   ibuf_space,
  fetch_wf_scheduler_if.master fetch,
  output logic [NUM_WF-1:0]   active_mask,
  output logic                busy
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_req_valid, w_req_valid_nxt;
  logic [WF_ID_W-1:0] r_grant, w_grant_nxt;
  logic [WF_ID_W-1:0] r_rr_ptr, w_rr_nxt;
  logic               r_busy, w_busy_nxt;

  logic [NUM_WF-1:0]  w_active, w_blocked, w_elig;
  logic               w_any;
  logic [WF_ID_W-1:0] w_pick, w_idx;
  logic               w_rsp_hit, w_blk_valid;

  // (a + k) mod NUM_WF, for a < NUM_WF and 0 <= k < NUM_WF.
  function automatic logic [WF_ID_W-1:0] wrap_add(input logic [WF_ID_W-1:0] a,
                                                  input int k);
    int s;
    s = int'(a) + k;
    if (s >= NUM_WF) s = s - NUM_WF;
    return WF_ID_W'(s);
  endfunction

  for (genvar g = 0; g < NUM_WF; g++) begin : g_slot
    fetch_wf_slot #(.WF_ID_W(WF_ID_W), .SLOT_ID(WF_ID_W'(g))) u_slot (
      .clk          (clk),
      .rst          (rst),
      .i_disp_valid (wf_dispatch_valid),
      .i_disp_id    (wf_dispatch_id),
      .i_done_valid (wf_done_valid),
      .i_done_id    (wf_done_id),
      .i_res_valid  (br_resolve_valid),
      .i_res_id     (br_resolve_id),
      .i_blk_valid  (w_blk_valid),
      .i_blk_id     (r_grant),
      .o_active     (w_active[g]),
      .o_blocked    (w_blocked[g])
    );
  end

  assign w_elig = w_active & ~w_blocked & ibuf_space;
  assign w_any  = |w_elig;

  // Scan offsets from high to low so the smallest offset from rr_ptr wins.
  always_comb begin
    w_pick = '0;
    w_idx  = '0;
    for (int k = NUM_WF - 1; k >= 0; k--) begin
      w_idx = wrap_add(r_rr_ptr, k);
      if (w_elig[w_idx]) w_pick = w_idx;
    end
  end

  assign w_rsp_hit   = (r_state == S_WAIT) && fetch.fetch_rsp_valid &&
                       (fetch.fetch_rsp_wfid == r_grant);
  assign w_blk_valid = w_rsp_hit && fetch.fetch_rsp_is_branch;

  // State register (plus the registered outputs).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_req_valid <= 1'b0;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_valid <= w_req_valid_nxt;
      r_grant     <= w_grant_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any)               w_state_nxt = S_REQ;
      S_REQ:   if (fetch.fetch_req_ack) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_rsp_hit)           w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    w_req_valid_nxt = (w_state_nxt == S_REQ);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_grant_nxt     = (r_state == S_IDLE && w_any) ? w_pick : r_grant;
    w_rr_nxt        = w_rsp_hit ? wrap_add(r_grant, 1) : r_rr_ptr;
  end

  assign fetch.fetch_req_valid = r_req_valid;
  assign fetch.fetch_req_wfid  = r_grant;
  assign active_mask           = w_active;
  assign busy                  = r_busy;
endmodule

// File: tb/tb_fetch_wf_scheduler.sv
// Directed bench for fetch_wf_scheduler: a vector table for reset and
// round-robin behaviour, then hand-written multi-cycle sequences for request
// hold, branch blocking, mid-flight retire and mid-operation reset.
module tb_fetch_wf_scheduler;
  localparam int NUM_WF  = 40;
  localparam int WF_ID_W = 6;
  localparam logic [39:0] ALL = {40{1'b1}};
  localparam logic [39:0] B0  = 40'd1;
  localparam logic [39:0] B1  = 40'd1 << 1;
  localparam logic [39:0] B5  = 40'd1 << 5;
  localparam logic [39:0] B10 = 40'd1 << 10;
  localparam logic [39:0] B30 = 40'd1 << 30;
  localparam logic [39:0] B39 = 40'd1 << 39;

  logic clk, rst;
  logic dv, xv, rv;
  logic [WF_ID_W-1:0] did, xid, rid;
  logic [NUM_WF-1:0] sp;
  logic [NUM_WF-1:0] active_mask;
  logic busy;

  fetch_wf_scheduler_if #(.WF_ID_W(WF_ID_W)) fif ();

  fetch_wf_scheduler #(.NUM_WF(NUM_WF), .WF_ID_W(WF_ID_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .wf_dispatch_valid (dv),
    .wf_dispatch_id    (did),
    .wf_done_valid     (xv),
    .wf_done_id        (xid),
    .br_resolve_valid  (rv),
    .br_resolve_id     (rid),
    .ibuf_space        (sp),
    .fetch             (fif),
    .active_mask       (active_mask),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        dv;  logic [5:0] did;
    logic        xv;  logic [5:0] xid;
    logic        ack;
    logic        pv;  logic [5:0] pid; logic pbr;
    logic        ev;  logic [5:0] eid; logic eb; logic [39:0] ea;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(bit r, bit dv_, int did_, bit xv_, int xid_, bit ack_,
                              bit pv_, int pid_, bit pbr_,
                              bit ev_, int eid_, bit eb_, logic [39:0] ea_);
    vec_t v;
    v.rst = r;   v.dv = dv_;  v.did = 6'(did_);
    v.xv = xv_;  v.xid = 6'(xid_);
    v.ack = ack_;
    v.pv = pv_;  v.pid = 6'(pid_); v.pbr = pbr_;
    v.ev = ev_;  v.eid = 6'(eid_); v.eb = eb_; v.ea = ea_;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    rst = 1'b1; dv = 1'b0; did = '0; xv = 1'b0; xid = '0; rv = 1'b0; rid = '0;
    sp = ALL;
    fif.fetch_req_ack = 1'b0; fif.fetch_rsp_valid = 1'b0;
    fif.fetch_rsp_wfid = '0;  fif.fetch_rsp_is_branch = 1'b0;
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input int id, input bit br);
    fif.fetch_rsp_valid = 1'b1;
    fif.fetch_rsp_wfid = 6'(id);
    fif.fetch_rsp_is_branch = br;
  endtask

  task automatic chk_req(input string nm, input bit v, input int id);
    chk({nm, " valid"}, 64'(fif.fetch_req_valid), 64'(v));
    if (v) chk({nm, " wfid"}, 64'(fif.fetch_req_wfid), 64'(id));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // rst dv did xv xid ack pv pid br | valid wfid busy active
    tbl.push_back(mk(0,1, 3,1, 3,1,1, 3,1, 0, 0,0,0));
    tbl.push_back(mk(0,1, 3,1, 3,1,1, 3,1, 0, 0,0,0));
    tbl.push_back(mk(1,1, 0,0, 0,0,0, 0,0, 0, 0,0,B0));
    tbl.push_back(mk(1,1, 5,0, 0,0,0, 0,0, 1, 0,1,B0|B5));
    tbl.push_back(mk(1,1,39,0, 0,1,0, 0,0, 0, 0,1,B0|B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,0,1, 0,0, 0, 0,0,B0|B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 1, 5,1,B0|B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,1,0, 0,0, 0, 5,1,B0|B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,0,1, 5,0, 0, 5,0,B0|B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 1,39,1,B0|B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,1,0, 0,0, 0,39,1,B0|B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,0,1,39,0, 0,39,0,B0|B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 1, 0,1,B0|B5|B39)); // wrap to 0
    tbl.push_back(mk(1,0, 0,0, 0,1,0, 0,0, 0, 0,1,B0|B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,0,1, 5,0, 0, 0,1,B0|B5|B39)); // wrong id
    tbl.push_back(mk(1,0, 0,0, 0,0,1, 0,0, 0, 0,0,B0|B5|B39));
    tbl.push_back(mk(1,0, 0,1, 0,0,0, 0,0, 1, 5,1,B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,0,1, 5,0, 1, 5,1,B5|B39));    // rsp in REQ
    tbl.push_back(mk(1,0, 0,0, 0,1,0, 0,0, 0, 5,1,B5|B39));
    tbl.push_back(mk(1,0, 0,0, 0,0,1, 5,0, 0, 5,0,B5|B39));
    tbl.push_back(mk(1,0, 0,1, 5,0,0, 0,0, 1,39,1,B39));
    tbl.push_back(mk(1,0, 0,1,39,1,0, 0,0, 0,39,1,0));
    tbl.push_back(mk(1,0, 0,0, 0,0,1,39,1, 0,39,0,0));
    tbl.push_back(mk(1,0, 0,0, 0,0,0, 0,0, 0, 0,0,0));

    clr();
    rst = 1'b0;
    #1;
    foreach (tbl[i]) begin
      clr();
      rst = tbl[i].rst; dv = tbl[i].dv; did = tbl[i].did;
      xv = tbl[i].xv;   xid = tbl[i].xid;
      fif.fetch_req_ack = tbl[i].ack;
      fif.fetch_rsp_valid = tbl[i].pv; fif.fetch_rsp_wfid = tbl[i].pid;
      fif.fetch_rsp_is_branch = tbl[i].pbr;
      step();
      chk($sformatf("vec%0d valid", i), 64'(fif.fetch_req_valid), 64'(tbl[i].ev));
      if (tbl[i].ev || !tbl[i].rst)
        chk($sformatf("vec%0d wfid", i), 64'(fif.fetch_req_wfid), 64'(tbl[i].eid));
      chk($sformatf("vec%0d busy", i), 64'(busy), 64'(tbl[i].eb));
      chk($sformatf("vec%0d active", i), 64'(active_mask), 64'(tbl[i].ea));
    end

    // Request hold for 10 cycles without ack; space of slot 10 drops midway.
    clr(); dv = 1'b1; did = 6'd10; step();
    chk("hold act", 64'(active_mask), 64'(B10));
    clr(); step(); chk_req("hold grant", 1, 10);
    for (int i = 0; i < 10; i++) begin
      clr();
      if (i >= 2) sp = ALL & ~B10;
      step(); chk_req($sformatf("hold c%0d", i), 1, 10);
    end
    clr(); sp = ALL & ~B10; fif.fetch_req_ack = 1'b1; step();
    chk_req("hold ack", 0, 0); chk("hold ack busy", 64'(busy), 1);
    clr(); sp = ALL & ~B10; rsp(10, 0); step();
    chk("hold rsp busy", 64'(busy), 0);
    clr(); sp = ALL & ~B10; xv = 1'b1; xid = 6'd10; step();
    chk_req("hold nospace", 0, 0); chk("hold done act", 64'(active_mask), 0);

    // Branch block on slot 7.
    clr(); dv = 1'b1; did = 6'd7; step();
    clr(); step(); chk_req("br grant", 1, 7);
    clr(); fif.fetch_req_ack = 1'b1; step();
    clr(); rsp(7, 1); step(); chk("br rsp busy", 64'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      clr(); step(); chk_req($sformatf("br blocked c%0d", i), 0, 0);
    end
    clr(); rv = 1'b1; rid = 6'd7; step(); chk_req("br resolve edge", 0, 0);
    clr(); step(); chk_req("br regrant", 1, 7);
    clr(); fif.fetch_req_ack = 1'b1; step();
    clr(); rsp(7, 1); rv = 1'b1; rid = 6'd7; step(); chk("br race busy", 64'(busy), 0);
    for (int i = 0; i < 2; i++) begin
      clr(); step(); chk_req($sformatf("br race blocked c%0d", i), 0, 0);
    end
    clr(); rv = 1'b1; rid = 6'd7; step();
    clr(); step(); chk_req("br race regrant", 1, 7);
    clr(); fif.fetch_req_ack = 1'b1; step();
    clr(); rsp(7, 0); xv = 1'b1; xid = 6'd7; step();
    chk("br done busy", 64'(busy), 0); chk("br done act", 64'(active_mask), 0);
    clr(); step(); chk_req("br idle", 0, 0);

    // Retire slot 2 while waiting for its response.
    clr(); dv = 1'b1; did = 6'd2; step();
    clr(); step(); chk_req("ret grant", 1, 2);
    clr(); fif.fetch_req_ack = 1'b1; step(); chk("ret wait busy", 64'(busy), 1);
    clr(); xv = 1'b1; xid = 6'd2; step();
    chk("ret act", 64'(active_mask), 0); chk("ret still busy", 64'(busy), 1);
    clr(); rsp(2, 1); step(); chk("ret rsp busy", 64'(busy), 0);
    clr(); step(); chk_req("ret no grant", 0, 0);
    clr(); dv = 1'b1; did = 6'd4; xv = 1'b1; xid = 6'd4; step();
    chk("dispdone act", 64'(active_mask), 0);
    clr(); step(); chk_req("dispdone no grant", 0, 0);

    // Reset while in WAIT; late response ignored; rr_ptr back to 0.
    clr(); dv = 1'b1; did = 6'd9; step();
    clr(); step(); chk_req("rst grant", 1, 9);
    clr(); fif.fetch_req_ack = 1'b1; step();
    clr(); rst = 1'b0; step();
    chk("rst busy", 64'(busy), 0); chk_req("rst req", 0, 0);
    chk("rst wfid", 64'(fif.fetch_req_wfid), 0);
    chk("rst act", 64'(active_mask), 0);
    clr(); rsp(9, 1); step(); chk("rst late rsp busy", 64'(busy), 0);
    clr(); sp = ALL & ~(B1 | B30); dv = 1'b1; did = 6'd30; step();
    clr(); sp = ALL & ~(B1 | B30); dv = 1'b1; did = 6'd1; step();
    chk("rst act2", 64'(active_mask), 64'(B1 | B30));
    clr(); step(); chk_req("rst rr0 grant", 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
